vga_timing_gen: RTL

//  Parametrised successor to the fixed 1024x768 VGA timing block.
//  - Generates pixel counters, sync, blank and frame markers for any mode.
//  - Sync/blank outputs are delayed by a programmable pipeline depth, so they

---
 rtl/vga_timing_pkg.sv | 51 +++++
 rtl/vga_timing_gen_pipe_delay.sv | 51 +++++
 rtl/vga_timing_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared types, video mode constants and a sync polarity
//                helper for the VGA timing generator.
//  Contents    : timing_t        - active/porch/sync sizes plus polarities
//                MODE_*          - common video modes
//                polarise()      - maps an active-high sync to its pin level
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        hs_pol;
        logic        vs_pol;
    } timing_t;

    localparam timing_t MODE_1024x768 = '{
        h_active: 16'd1024, h_fp: 16'd24,  h_sync: 16'd136, h_bp: 16'd160,
        v_active: 16'd768,  v_fp: 16'd3,   v_sync: 16'd6,   v_bp: 16'd29,
        hs_pol:   1'b0,     vs_pol: 1'b0
    };

    localparam timing_t MODE_640x480 = '{
        h_active: 16'd640,  h_fp: 16'd16,  h_sync: 16'd96,  h_bp: 16'd48,
        v_active: 16'd480,  v_fp: 16'd10,  v_sync: 16'd2,   v_bp: 16'd33,
        hs_pol:   1'b0,     vs_pol: 1'b0
    };

    localparam timing_t MODE_1280x720 = '{
        h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40,  h_bp: 16'd220,
        v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,   v_bp: 16'd20,
        hs_pol:   1'b1,     vs_pol: 1'b1
    };

    // Active-high "in sync" flag to the level driven on the pin:
    // pol=0 gives an active-low pulse, pol=1 an active-high pulse.
    function automatic logic polarise(input logic active, input logic pol);
        return active ^ ~pol;
    endfunction

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_timing_gen_pipe_delay.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_delay
//  Description : Enable-gated shift register of DEPTH stages, WIDTH bits wide.
//                DEPTH=0 is a plain wire-through with no register.
//  Ports       : clk    in  1      clock
//                rst_n  in  1      synchronous reset, active-low; loads RST_VAL
//                i_en   in  1      advance enable; 0 holds every stage
//                i_d    in  WIDTH  data in
//                o_q    out WIDTH  data out, DEPTH enabled cycles later
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_delay #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        assign o_q = i_d;

        // Control inputs are meaningless without a register.
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst_n, i_en};
    end else begin : g_shift
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_stage[i] <= RST_VAL;
                end
            end else if (i_en) begin
                r_stage[0] <= i_d;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule : pipe_delay
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA timing generator. Produces pixel/line
//                counters, polarity-corrected syncs, blank and frame markers.
//                Sync/blank are delayed DELAY enabled cycles to line up with a
//                pixel pipeline of known latency.
//  Ports       : pixel_clk_in     in  1        pixel clock
//                rst_n_in         in  1        synchronous reset, active-low
//                en_in            in  1        advance enable; 0 freezes state
//                hcount_out       out HW       pixel index on line (undelayed)
//                vcount_out       out VW       line index (undelayed)
//                hsync_out        out 1        hsync at HS_POL level (delayed)
//                vsync_out        out 1        vsync at VS_POL level (delayed)
//                blank_out        out 1        1 outside active area (delayed)
//                frame_start_out  out 1        pulse at (0,0) while enabled
//                frame_count_out  out FRAME_W  completed frames, wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned DELAY    = 0,
    parameter int unsigned FRAME_W  = 16,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic               pixel_clk_in,
    input  logic               rst_n_in,
    input  logic               en_in,
    output logic [HW-1:0]      hcount_out,
    output logic [VW-1:0]      vcount_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               blank_out,
    output logic               frame_start_out,
    output logic [FRAME_W-1:0] frame_count_out
);

    // ------------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------------
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_porch
        $error("vga_timing_gen: every porch and sync width must be >= 1");
    end

    if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_chk_active
        $error("vga_timing_gen: active width and height must be >= 1");
    end

    if (DELAY > 15) begin : g_chk_delay
        $error("vga_timing_gen: DELAY must be in 0..15");
    end

    // ------------------------------------------------------------------------
    // Decode boundaries, sized to the counters
    // ------------------------------------------------------------------------
    localparam logic [HW-1:0] c_H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] c_HS_FIRST   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] c_V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] c_V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] c_VS_FIRST   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Delay-line flush value: both syncs at their inactive level, blanked.
    localparam logic [2:0]    c_FLUSH      = {~HS_POL, ~VS_POL, 1'b1};

    // ------------------------------------------------------------------------
    // Counters: the raster position is the whole frame state
    // ------------------------------------------------------------------------
    logic [HW-1:0]      r_hcount;
    logic [VW-1:0]      r_vcount;
    logic [FRAME_W-1:0] r_frame_count;
    logic               w_h_last;
    logic               w_v_last;

    assign w_h_last = (r_hcount == c_H_LAST);
    assign w_v_last = (r_vcount == c_V_LAST);

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_n_in) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_count <= '0;
        end else if (en_in) begin
            if (w_h_last) begin
                r_hcount <= '0;
                if (w_v_last) begin
                    r_vcount      <= '0;
                    r_frame_count <= r_frame_count + 1'b1;
                end else begin
                    r_vcount <= r_vcount + 1'b1;
                end
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Raw decode and polarity
    // ------------------------------------------------------------------------
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic       w_blank_raw;
    logic [2:0] w_raw;
    logic [2:0] w_dly;

    assign w_hs_raw    = (r_hcount >= c_HS_FIRST) && (r_hcount <= c_HS_LAST);
    assign w_vs_raw    = (r_vcount >= c_VS_FIRST) && (r_vcount <= c_VS_LAST);
    assign w_blank_raw = (r_hcount >= c_H_ACT) || (r_vcount >= c_V_ACT);

    // Polarity is applied before the delay so the flush value is simply the
    // inactive pin level.
    assign w_raw = {polarise(w_hs_raw, HS_POL),
                    polarise(w_vs_raw, VS_POL),
                    w_blank_raw};

    // Advancing only on en_in keeps the delayed outputs aligned with the
    // counters across stalls.
    pipe_delay #(
        .WIDTH   (3),
        .DEPTH   (DELAY),
        .RST_VAL (c_FLUSH)
    ) u_pipe_delay (
        .clk   (pixel_clk_in),
        .rst_n (rst_n_in),
        .i_en  (en_in),
        .i_d   (w_raw),
        .o_q   (w_dly)
    );

    assign hsync_out       = w_dly[2];
    assign vsync_out       = w_dly[1];
    assign blank_out       = w_dly[0];

    assign hcount_out      = r_hcount;
    assign vcount_out      = r_vcount;
    assign frame_count_out = r_frame_count;
    assign frame_start_out = en_in && (r_hcount == '0) && (r_vcount == '0);

endmodule : vga_timing_gen
`default_nettype wire
